// File: rtl/cg_count_cmp.sv
// Compare/event stage for cg_counter: match pulse, sticky irq, fire count and
// preset/stop feedback. Define CG_COUNT_CMP_GE_EN to hit on i_count >= r_cmp.
module cg_count_cmp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_count,
  input  logic                  i_cfg_we,
  input  logic [DATA_WIDTH-1:0] i_cfg_cmp,
  input  logic                  i_cfg_mode,
  input  logic                  i_arm,
  input  logic                  i_disarm,
  input  logic                  i_irq_ack,
  output logic                  o_prst,
  output logic                  o_stop,
  output logic                  o_match,
  output logic                  o_irq,
  output logic [7:0]            o_fire_cnt,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RELOAD = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_cmp;
  logic                  r_mode;
  logic                  r_match;
  logic                  r_irq;
  logic [7:0]            r_fire_cnt;
  logic                  w_hit;
  logic                  w_fire;

`ifdef CG_COUNT_CMP_GE_EN
  assign w_hit = (i_count >= r_cmp);
`else
  assign w_hit = (i_count == r_cmp);
`endif

  // Disarm suppresses a coincident hit entirely: no match, irq or count.
  assign w_fire = (r_state == ST_ARMED) && w_hit && !i_disarm;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cmp      <= '0;
      r_mode     <= 1'b0;
      r_match    <= 1'b0;
      r_irq      <= 1'b0;
      r_fire_cnt <= 8'd0;
    end else begin
      r_match <= w_fire;
      if (i_cfg_we && r_state == ST_IDLE) begin
        r_cmp  <= i_cfg_cmp;
        r_mode <= i_cfg_mode;
      end
      if (w_fire)
        r_irq <= 1'b1;
      else if (i_irq_ack)
        r_irq <= 1'b0;
      if (w_fire && r_fire_cnt != 8'hFF)
        r_fire_cnt <= r_fire_cnt + 8'd1;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (!i_disarm && i_arm) begin
            r_state    <= ST_ARMED;
            r_fire_cnt <= 8'd0;
          end else if (i_disarm) begin
            r_state <= ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (i_disarm)
            r_state <= ST_IDLE;
          else if (w_hit)
            r_state <= r_mode ? ST_RELOAD : ST_DONE;
        end
        ST_RELOAD: r_state <= i_disarm ? ST_IDLE : ST_ARMED;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_prst     = (r_state == ST_RELOAD);
  assign o_stop     = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign o_match    = r_match;
  assign o_irq      = r_irq;
  assign o_fire_cnt = r_fire_cnt;
  assign o_state    = r_state;

endmodule

// File: tb/tb_cg_count_cmp.sv
// Bench for cg_count_cmp: vector table, periodic/saturation run against a
// simple counter model, mid-RELOAD reset and the compare-skip case.
module tb_cg_count_cmp;

  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst, i_cfg_we, i_cfg_mode, i_arm, i_disarm, i_irq_ack;
  logic [DW-1:0] i_count, i_cfg_cmp, drv_cnt, mcnt;
  logic          use_model;
  logic          o_prst, o_stop, o_match, o_irq;
  logic [7:0]    o_fire_cnt;
  logic [1:0]    o_state;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  cg_count_cmp #(.DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_count(i_count),
    .i_cfg_we(i_cfg_we), .i_cfg_cmp(i_cfg_cmp), .i_cfg_mode(i_cfg_mode),
    .i_arm(i_arm), .i_disarm(i_disarm), .i_irq_ack(i_irq_ack),
    .o_prst(o_prst), .o_stop(o_stop), .o_match(o_match), .o_irq(o_irq),
    .o_fire_cnt(o_fire_cnt), .o_state(o_state)
  );

  // Stand-in for cg_counter: default 0, presets on o_prst, holds on o_stop.
  always @(posedge i_clk) begin
    if (i_rst)        mcnt <= '0;
    else if (o_prst)  mcnt <= '0;
    else if (!o_stop) mcnt <= mcnt + 1;
  end
  assign i_count = use_model ? mcnt : drv_cnt;

  typedef struct {
    string         nm;
    logic          rst, we, mode, arm, dis, ack, usem, chk;
    logic [DW-1:0] cnt, cmp;
    logic          m, irq, prst, stop;
    logic [7:0]    fc;
    logic [1:0]    st;
  } vec_t;

  vec_t q[$];

  function automatic vec_t mk(input string nm, input logic rst, input logic [DW-1:0] cnt,
                              input logic we, input logic [DW-1:0] cmp, input logic mode,
                              input logic arm, input logic dis, input logic ack,
                              input logic m, input logic irq, input logic [7:0] fc,
                              input logic [1:0] st);
    vec_t v;
    v.nm = nm; v.rst = rst; v.cnt = cnt; v.we = we; v.cmp = cmp; v.mode = mode;
    v.arm = arm; v.dis = dis; v.ack = ack; v.usem = 1'b0; v.chk = 1'b1;
    v.m = m; v.irq = irq; v.fc = fc; v.st = st;
    v.prst = (st == 2'd2);
    v.stop = (st == 2'd0) || (st == 2'd3);
    return v;
  endfunction

  // Expected results are queued when driven and popped once the edge lands.
  always @(posedge i_clk) begin
    #1;
    if (q.size() > 0) begin
      vec_t e;
      e = q.pop_front();
      if (e.chk) begin
        total++;
        if ({o_match, o_irq, o_fire_cnt, o_state, o_prst, o_stop} !==
            {e.m, e.irq, e.fc, e.st, e.prst, e.stop}) begin
          bad++;
          $display("FAIL %s: got match=%0b irq=%0b fc=%0d st=%0d prst=%0b stop=%0b want match=%0b irq=%0b fc=%0d st=%0d prst=%0b stop=%0b",
                   e.nm, o_match, o_irq, o_fire_cnt, o_state, o_prst, o_stop,
                   e.m, e.irq, e.fc, e.st, e.prst, e.stop);
        end
      end
    end
  end

  task automatic apply(input vec_t v);
    @(negedge i_clk);
    i_rst = v.rst; drv_cnt = v.cnt; i_cfg_we = v.we; i_cfg_cmp = v.cmp;
    i_cfg_mode = v.mode; i_arm = v.arm; i_disarm = v.dis; i_irq_ack = v.ack;
    use_model = v.usem;
    q.push_back(v);
    @(posedge i_clk);
    #2;
  endtask

  vec_t tbl[19];

  initial begin
    i_rst = 1'b1; drv_cnt = '0; i_cfg_we = 1'b0; i_cfg_cmp = '0; i_cfg_mode = 1'b0;
    i_arm = 1'b0; i_disarm = 1'b0; i_irq_ack = 1'b0; use_model = 1'b0;

    //                  name      rst cnt we cmp md arm dis ack  m irq fc st
    tbl[0]  = mk("rst0",     1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mk("rst1",     1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[2]  = mk("cfg5",     0, 0, 1, 5, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[3]  = mk("arm",      0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
    tbl[4]  = mk("cfg_ign",  0, 0, 1, 9, 1, 1, 0, 0,  0, 0, 0, 1);
    tbl[5]  = mk("c1",       0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    tbl[6]  = mk("c2",       0, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    tbl[7]  = mk("c3",       0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    tbl[8]  = mk("c4",       0, 4, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    tbl[9]  = mk("hit5",     0, 5, 0, 0, 0, 0, 0, 0,  1, 1, 1, 3);
    tbl[10] = mk("hold5",    0, 5, 0, 0, 0, 0, 0, 0,  0, 1, 1, 3);
    tbl[11] = mk("ack",      0, 5, 0, 0, 0, 0, 0, 1,  0, 0, 1, 3);
    tbl[12] = mk("rearm",    0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
    tbl[13] = mk("hit_ack",  0, 5, 0, 0, 0, 0, 0, 1,  1, 1, 1, 3);
    tbl[14] = mk("arm2",     0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 1);
    tbl[15] = mk("hit_dis",  0, 5, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0);
    tbl[16] = mk("idle5",    0, 5, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    tbl[17] = mk("arm_dis",  0, 0, 0, 0, 0, 1, 1, 0,  0, 1, 0, 0);
    tbl[18] = mk("ack2",     0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0);
    for (int i = 0; i < 19; i++) apply(tbl[i]);

    // Periodic cmp=3 with counter model: 3 quiet cycles, match+RELOAD, back ARMED.
    // Runs to 300 matches to cover saturation of the fire count.
    apply(mk("p_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("p_cfg", 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    begin
      vec_t v;
      v = mk("p_arm", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      v.usem = 1'b1;
      apply(v);
      for (int p = 0; p < 300; p++) begin
        logic [7:0] fc_now, fc_prev;
        fc_now  = (p + 1 > 255) ? 8'd255 : 8'(p + 1);
        fc_prev = (p > 255) ? 8'd255 : 8'(p);
        for (int k = 0; k < 3; k++) begin
          v = mk("p_quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, (p > 0), fc_prev, 1);
          v.usem = 1'b1;
          apply(v);
        end
        v = mk("p_match", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, fc_now, 2);
        v.usem = 1'b1;
        apply(v);
        if (p == 299) break;
        v = mk("p_reload", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, fc_now, 1);
        v.usem = 1'b1;
        apply(v);
      end
      // Reset lands while in RELOAD.
      v = mk("rst_reload", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.usem = 1'b1;
      apply(v);
    end

    // Counter skips the compare value: 2 -> 6 with cmp=4.
    apply(mk("g_cfg", 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("g_arm", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    apply(mk("g_c2",  0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef CG_COUNT_CMP_GE_EN
    apply(mk("g_c6",  0, 6, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3));
    apply(mk("g_c6b", 0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3));
`else
    apply(mk("g_c6",  0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk("g_c6b", 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif

    repeat (2) @(posedge i_clk);
    #3;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
